flag_stack_register: RTL and testbench
======================================

// Module: flag_stack_register
//
// PURPOSE
//  Parametrised successor to the processor's flag register. Holds NFLAGS
//  ALU status flags and exposes a true/complement condition array to the
//  control code generator.
//  Adds an update qualifier and a LIFO save/restore stack, so flags survive
//  subroutine calls and interrupts. Sits between the ALU, the IR condition
//  field and the control code generator.
//
// PARAMETERS
//  NFLAGS  4  number of ALU status flags (bit0=Z, bit1=C, bit2=P, bit3=PO, ...)
//  DEPTH   4  number of save-stack entries (>=1)
//  SELW    $clog2(2*NFLAGS)  width of condition select (derived, localparam)
//  SPW     $clog2(DEPTH+1)   width of stack pointer/count (derived, localparam)
//
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  s_al       in   1       update qualifier: load in_flags this cycle
//  in_flags   in   NFLAGS  flag values from ALU
//  oc_fl      in   SELW    condition select from IR
//  push       in   1       save current live flags onto stack
//  pop        in   1       restore live flags from stack top
//  carry      out  1       live flag[1], to ALU carry-in
//  fl         out  1       selected condition, to control code generator
//  flags      out  NFLAGS  live flag register
//  depth_cnt  out  SPW     number of occupied stack entries
//  full       out  1       depth_cnt == DEPTH
//  empty      out  1       depth_cnt == 0
//
// BEHAVIOUR
//  - Reset: flags=0, depth_cnt=0, stack contents cleared to 0, full=0, empty=1,
//    carry=0. fl is derived from flags, so fl=cond[oc_fl] with flags=0.
//  - Condition array: cond[2i] = flags[i] and cond[2i+1] = ~flags[i].
//  - fl = cond[oc_fl], combinational from the registered flags (0 cycles
//    after the flags register changes).
//  - fl = 0 when oc_fl >= 2*NFLAGS.
//  - carry = flags[1], also combinational from the registered flags.
//  - Live update: if s_al, flags <= in_flags at posedge, so the new values
//    are visible 1 cycle later. No s_al: flags hold.
//  - push alone, not full:
//    * stack[depth_cnt] <= flags (the pre-update value)
//    * depth_cnt++
//    * s_al in the same cycle still loads in_flags into the live register.
//  - pop alone, not empty:
//    * flags <= stack[depth_cnt-1], and pop overrides s_al
//    * depth_cnt--
//  - push && pop in the same cycle: the stack and depth_cnt are unchanged.
//    The live register follows s_al only.
//  - push when full: ignored, no stack write and no count change. s_al still
//    applies.
//  - pop when empty: ignored, flags follow s_al.
//  - rst has priority over all inputs. rst asserted mid-sequence discards the
//    whole stack.
//  - Stack is a pure LIFO indexed by depth_cnt. Entries above depth_cnt are
//    don't-care and are not observable.
//
// CONFIGURATION
//  FLAGSTK_ERR_EN defined:
//    * Adds output ports ovf (1), udf (1) and input port err_clr (1).
//    * ovf is sticky: set the cycle after a push while full.
//    * udf is sticky: set the cycle after a pop while empty.
//    * push && pop together sets neither flag.
//    * Both flags clear on rst or err_clr. If err_clr and a new error occur
//      in the same cycle, the error wins (flag set).
//  FLAGSTK_ERR_EN undefined:
//    * Ports ovf, udf and err_clr are absent.
//    * Illegal push/pop is silently ignored, as described above.
//
// TESTING
//  1. rst; s_al=1 with in_flags=4'b0011, oc_fl=0 -> next cycle flags=0011,
//     carry=1, fl=1. Then oc_fl=3 -> fl=0 (~C). Then oc_fl=5 -> fl=1 (~P).
//  2. Sequence with flags=0011:
//     * push -> depth_cnt=1, empty=0.
//     * s_al with in_flags=1100 -> flags=1100.
//     * pop -> flags=0011, depth_cnt=0, empty=1.
//  3. Overflow/underflow (DEPTH=4):
//     * 5 pushes with flags 1..5 loaded between them -> full=1, depth_cnt=4,
//       ovf=1 (ERR_EN).
//     * 4 pops -> flags read back 4,3,2,1.
//     * 5th pop -> flags unchanged, udf=1.
//  4. Same-cycle events:
//     * pop+s_al (in_flags=1111, top=0101) -> flags=0101.
//     * push+s_al -> stored entry = old flags, live = in_flags.
//     * push+pop -> depth_cnt unchanged, no error flag set.
//  5. rst asserted with depth_cnt=3 and flags=1010 -> next cycle flags=0,
//     depth_cnt=0, empty=1, ovf=udf=0. A following pop leaves flags=0.
//  6. NFLAGS=3, oc_fl=6 and 7 -> fl=0. Sweep oc_fl 0..5 against the
//     cond[] model for all 8 flag values.

Source files
------------

// File: rtl/flag_stack_register.sv
// ALU flag register with true/complement condition select and a LIFO save/restore stack.
// Optional FLAGSTK_ERR_EN adds sticky overflow/underflow outputs and an err_clr input.
module flag_stack_register #(
  parameter  int NFLAGS = 4,
  parameter  int DEPTH  = 4,
  localparam int SELW   = $clog2(2*NFLAGS),
  localparam int SPW    = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_al,
  input  logic [NFLAGS-1:0] in_flags,
  input  logic [SELW-1:0]   oc_fl,
  input  logic              push,
  input  logic              pop,
`ifdef FLAGSTK_ERR_EN
  input  logic              err_clr,
  output logic              ovf,
  output logic              udf,
`endif
  output logic              carry,
  output logic              fl,
  output logic [NFLAGS-1:0] flags,
  output logic [SPW-1:0]    depth_cnt,
  output logic              full,
  output logic              empty
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [SPW-1:0]    depth_cnt_q, depth_cnt_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [NFLAGS-1:0] stack_d [DEPTH];
  logic [2*NFLAGS-1:0] cond;
  logic [IDXW-1:0]   wr_idx, rd_idx;
  logic              push_ok, pop_ok;

  assign full    = (depth_cnt_q == SPW'(DEPTH));
  assign empty   = (depth_cnt_q == '0);
  assign wr_idx  = IDXW'(depth_cnt_q);
  assign rd_idx  = IDXW'(depth_cnt_q - SPW'(1));
  // Simultaneous push and pop cancel out; only s_al affects the live register.
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;

  always_comb begin
    flags_d     = s_al ? in_flags : flags_q;
    depth_cnt_d = depth_cnt_q;
    stack_d     = stack_q;
    if (pop_ok) begin
      flags_d     = stack_q[rd_idx];
      depth_cnt_d = depth_cnt_q - SPW'(1);
    end
    if (push_ok) begin
      stack_d[wr_idx] = flags_q;
      depth_cnt_d     = depth_cnt_q + SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      depth_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q     <= flags_d;
      depth_cnt_q <= depth_cnt_d;
      stack_q     <= stack_d;
    end
  end

  always_comb begin
    cond = '0;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      cond[2*i]   = flags_q[i];
      cond[2*i+1] = ~flags_q[i];
    end
    fl = 1'b0;
    if (32'(oc_fl) < 2*NFLAGS) fl = cond[oc_fl];
  end

  assign carry     = flags_q[1];
  assign flags     = flags_q;
  assign depth_cnt = depth_cnt_q;

`ifdef FLAGSTK_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (push && !pop && full)  ovf_d = 1'b1;
    if (pop && !push && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_flag_stack_register.sv
// Self-checking bench for flag_stack_register: directed scenarios, randomized traffic
// against a queue-based reference model, and an NFLAGS=3 condition-select sweep.
module tb_flag_stack_register;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, s_al = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [3:0] in_flags = '0;
  logic [2:0] oc_fl = '0;
  logic       carry, fl, full, empty;
  logic [3:0] flags;
  logic [2:0] depth_cnt;
  logic       ovf, udf;

  logic       rst3 = 1'b1, s_al3 = 1'b0, push3 = 1'b0, pop3 = 1'b0, err_clr3 = 1'b0;
  logic [2:0] in3 = '0, oc3 = '0, flags3;
  logic       carry3, fl3, full3, empty3;
  logic [1:0] depth3;
  logic       ovf3, udf3;

  flag_stack_register #(.NFLAGS(4), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .s_al(s_al), .in_flags(in_flags), .oc_fl(oc_fl),
    .push(push), .pop(pop),
`ifdef FLAGSTK_ERR_EN
    .err_clr(err_clr), .ovf(ovf), .udf(udf),
`endif
    .carry(carry), .fl(fl), .flags(flags), .depth_cnt(depth_cnt),
    .full(full), .empty(empty)
  );

  flag_stack_register #(.NFLAGS(3), .DEPTH(2)) u_dut3 (
    .clk(clk), .rst(rst3), .s_al(s_al3), .in_flags(in3), .oc_fl(oc3),
    .push(push3), .pop(pop3),
`ifdef FLAGSTK_ERR_EN
    .err_clr(err_clr3), .ovf(ovf3), .udf(udf3),
`endif
    .carry(carry3), .fl(fl3), .flags(flags3), .depth_cnt(depth3),
    .full(full3), .empty(empty3)
  );

`ifndef FLAGSTK_ERR_EN
  assign ovf  = 1'b0;
  assign udf  = 1'b0;
  assign ovf3 = 1'b0;
  assign udf3 = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: live flags, LIFO as a queue, sticky error bits.
  logic [3:0] m_flags = '0;
  logic [3:0] m_stk[$];
  bit         m_ovf = 0, m_udf = 0;

  function automatic bit cond_ref(input logic [31:0] f, input int sel, input int n);
    if (sel >= 2*n) return 1'b0;
    return (sel % 2 == 1) ? ~f[sel/2] : f[sel/2];
  endfunction

  task automatic model_step(input bit r, sa, input logic [3:0] inf, input bit pu, po, ec);
    logic [3:0] nxt;
    bit new_ovf = 0, new_udf = 0;
    if (r) begin
      m_flags = '0; m_stk.delete(); m_ovf = 0; m_udf = 0;
      return;
    end
    nxt = sa ? inf : m_flags;
    if (pu && !po) begin
      if (m_stk.size() < 4) m_stk.push_back(m_flags);
      else new_ovf = 1;
    end
    if (po && !pu) begin
      if (m_stk.size() > 0) nxt = m_stk.pop_back();
      else new_udf = 1;
    end
    m_flags = nxt;
    m_ovf = (m_ovf && !ec) || new_ovf;
    m_udf = (m_udf && !ec) || new_udf;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'(m_flags));
    check({tag, ".depth"}, 32'(depth_cnt), 32'(m_stk.size()));
    check({tag, ".full"},  32'(full), 32'(m_stk.size() == 4));
    check({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
    check({tag, ".carry"}, 32'(carry), 32'(m_flags[1]));
    check({tag, ".fl"},    32'(fl), 32'(cond_ref(32'(m_flags), int'(oc_fl), 4)));
`ifdef FLAGSTK_ERR_EN
    check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
    check({tag, ".udf"},   32'(udf), 32'(m_udf));
`endif
  endtask

  task automatic step(input string tag, input bit r, sa, input logic [3:0] inf,
                      input bit pu, po, input logic [2:0] oc, input bit ec);
    rst = r; s_al = sa; in_flags = inf; push = pu; pop = po; oc_fl = oc; err_clr = ec;
    model_step(r, sa, inf, pu, po, ec);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset state
    step("rst", 1, 0, 4'h0, 0, 0, 3'd0, 0);
    check("rst_empty_const", 32'(empty), 32'd1);

    // 1: load 0011, condition select
    step("t1", 0, 1, 4'b0011, 0, 0, 3'd0, 0);
    check("t1_fl_z", 32'(fl), 32'd1);
    check("t1_carry", 32'(carry), 32'd1);
    oc_fl = 3'd3; #1;
    check("t1_fl_nc", 32'(fl), 32'd0);
    oc_fl = 3'd5; #1;
    check("t1_fl_np", 32'(fl), 32'd1);

    // 2: push, overwrite, pop restores
    step("t2p", 0, 0, 4'h0, 1, 0, 3'd0, 0);
    check("t2_depth1", 32'(depth_cnt), 32'd1);
    step("t2l", 0, 1, 4'b1100, 0, 0, 3'd0, 0);
    step("t2o", 0, 0, 4'h0, 0, 1, 3'd0, 0);
    check("t2_restore", 32'(flags), 32'b0011);

    // 3: overflow then drain and underflow
    for (int k = 1; k <= 5; k++) begin
      step("t3l", 0, 1, 4'(k), 0, 0, 3'd1, 0);
      step("t3p", 0, 0, 4'h0, 1, 0, 3'd2, 0);
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_depth4", 32'(depth_cnt), 32'd4);
    for (int k = 4; k >= 1; k--) begin
      step("t3o", 0, 0, 4'h0, 0, 1, 3'd4, 0);
      check("t3_readback", 32'(flags), 32'(k));
    end
    step("t3u", 0, 0, 4'h0, 0, 1, 3'd0, 0);
    check("t3_unchanged", 32'(flags), 32'd1);
    step("t3c", 0, 0, 4'h0, 0, 0, 3'd0, 1);

    // 4: same-cycle events
    step("t4l", 0, 1, 4'b0101, 0, 0, 3'd0, 0);
    step("t4p", 0, 0, 4'h0, 1, 0, 3'd0, 0);
    step("t4a", 0, 1, 4'b1111, 0, 1, 3'd0, 0);
    check("t4_pop_wins", 32'(flags), 32'b0101);
    step("t4b", 0, 1, 4'b1001, 1, 0, 3'd0, 0);
    check("t4_push_live", 32'(flags), 32'b1001);
    step("t4c", 0, 0, 4'h0, 0, 1, 3'd0, 0);
    check("t4_push_stored", 32'(flags), 32'b0101);
    step("t4d", 0, 0, 4'h0, 1, 1, 3'd0, 0);
    step("t4e", 0, 0, 4'h0, 1, 1, 3'd0, 0);

    // 5: reset mid-sequence discards the stack
    for (int k = 0; k < 3; k++) step("t5p", 0, 0, 4'h0, 1, 0, 3'd0, 0);
    step("t5l", 0, 1, 4'b1010, 0, 0, 3'd0, 0);
    check("t5_depth3", 32'(depth_cnt), 32'd3);
    step("t5r", 1, 0, 4'h0, 0, 0, 3'd0, 0);
    step("t5o", 0, 0, 4'h0, 0, 1, 3'd0, 0);
    check("t5_flags0", 32'(flags), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step("rnd", ($urandom_range(31) == 0), $urandom_range(1), 4'($urandom),
           ($urandom_range(2) == 0), ($urandom_range(2) == 0),
           3'($urandom), ($urandom_range(15) == 0));
    end

    // 6: NFLAGS=3 select sweep including out-of-range selects
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int v = 0; v < 8; v++) begin
      s_al3 = 1'b1; in3 = 3'(v);
      @(posedge clk); #1;
      s_al3 = 1'b0;
      check("t6_flags", 32'(flags3), 32'(v));
      for (int s = 0; s < 8; s++) begin
        oc3 = 3'(s); #1;
        check("t6_fl", 32'(fl3), 32'(cond_ref(32'(v), s, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
